// File: rtl/enc_pkg.sv
// Shared definitions for the streaming priority encoder: state encoding and
// a constant log2 helper used to size the encoded index.
package enc_pkg;

  // Controller states: waiting for a word, or emitting its beats.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time width derivation.
  // Returns the smallest r with 2**r >= value. Values 0 and 1 give 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/penc_lsb.sv
// Combinational lowest-set-bit encoder.
// Reports the index of the lowest set bit, whether any bit is set, and
// whether exactly one bit is set.
module penc_lsb
  import enc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          iVec,
  output logic [clog2(N)-1:0]   oIdx,
  output logic                  oAny,
  output logic                  oOne
);

  localparam int W = clog2(N);

  logic          found;
  logic [N-1:0]  vec_minus_one;
  logic [N-1:0]  low_cleared;

  // Scan upward and latch the first set bit found; later bits cannot override it.
  always_comb begin
    oIdx  = {W{1'b0}};
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (iVec[k] && !found) begin
        oIdx  = W'(k);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Clearing the lowest set bit leaves zero only when at most one bit was set.
  always_comb begin
    vec_minus_one = iVec - {{(N-1){1'b0}}, 1'b1};
    low_cleared   = iVec & vec_minus_one;
    oAny          = (iVec != {N{1'b0}});
    oOne          = oAny && (low_cleared == {N{1'b0}});
  end

endmodule

// File: rtl/penc_stream.sv
// Streaming priority encoder: accepts a multi-hot word and emits one index per
// set bit, lowest first, on a valid/ready output port. An all-zero word yields
// a single beat flagged by oZero. All outputs are decoded from registers only.
module penc_stream
  import enc_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic [N-1:0]  iVec,
  input  logic          iVecValid,
  output logic          oVecReady,
  output logic [W-1:0]  oEnc,
  output logic          oEncValid,
  input  logic          iEncReady,
  output logic          oLast,
  output logic          oZero
);

  state_t        state;
  logic [N-1:0]  pend;
  logic          zflag;

  logic [W-1:0]  lsb_idx;
  logic          lsb_any;
  logic          lsb_one;
  logic [N-1:0]  clr_mask;
  logic          busy;
  logic          beat_last;

  penc_lsb #(
    .N (N)
  ) u_lsb (
    .iVec (pend),
    .oIdx (lsb_idx),
    .oAny (lsb_any),
    .oOne (lsb_one)
  );

  // Decode the per-beat view of the pending word; lsb_any only qualifies the
  // clear mask so an empty pend never clears a stray bit.
  always_comb begin
    busy      = (state == BUSY);
    beat_last = zflag || lsb_one;
    clr_mask  = {N{1'b0}};
    if (lsb_any) begin
      clr_mask[lsb_idx] = 1'b1;
    end else begin
      clr_mask = {N{1'b0}};
    end
  end

  // State, pending bits and zero flag; reset wins over any handshake.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      pend  <= {N{1'b0}};
      zflag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iVecValid) begin
            pend  <= iVec;
            zflag <= (iVec == {N{1'b0}});
            state <= BUSY;
          end
        end
        BUSY: begin
          // Input word is ignored here; upstream holds it until ready.
          if (iEncReady) begin
            pend <= pend & ~clr_mask;
            if (beat_last) begin
              state <= IDLE;
              zflag <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          pend  <= {N{1'b0}};
          zflag <= 1'b0;
        end
      endcase
    end
  end

  // Output decode from registered state only; nothing feeds through from inputs.
  always_comb begin
    oVecReady = !busy;
    oEncValid = busy;
    if (busy && !zflag) begin
      oEnc = lsb_idx;
    end else begin
      oEnc = {W{1'b0}};
    end
    oLast = busy && beat_last;
    oZero = busy && zflag;
  end

endmodule

// File: tb/tb_penc_stream.sv
// Directed self-checking bench for penc_stream in its default 4-to-2 form.
module tb_penc_stream;

  logic        iClk;
  logic        iRst;
  logic [3:0]  iVec;
  logic        iVecValid;
  logic        oVecReady;
  logic [1:0]  oEnc;
  logic        oEncValid;
  logic        iEncReady;
  logic        oLast;
  logic        oZero;

  int tests;
  int fails;

  penc_stream #(.N(4)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iVec      (iVec),
    .iVecValid (iVecValid),
    .oVecReady (oVecReady),
    .oEnc      (oEnc),
    .oEncValid (oEncValid),
    .iEncReady (iEncReady),
    .oLast     (oLast),
    .oZero     (oZero)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iVec = 4'b0000; iVecValid = 1'b0; iEncReady = 1'b0;
    step();
    tests++; if (oVecReady !== 1'b1) begin fails++; $display("FAIL reset_vready got=%b exp=1", oVecReady); end
    tests++; if (oEncValid !== 1'b0) begin fails++; $display("FAIL reset_evalid got=%b exp=0", oEncValid); end
    tests++; if (oLast !== 1'b0) begin fails++; $display("FAIL reset_last got=%b exp=0", oLast); end
    tests++; if (oZero !== 1'b0) begin fails++; $display("FAIL reset_zero got=%b exp=0", oZero); end
    tests++; if (oEnc !== 2'd0) begin fails++; $display("FAIL reset_enc got=%0d exp=0", oEnc); end
    iRst = 1'b0;
    step();
    tests++; if (oEncValid !== 1'b0) begin fails++; $display("FAIL idle_evalid got=%b exp=0", oEncValid); end
  endtask

  task automatic test_single();
    iVec = 4'b0100; iVecValid = 1'b1; iEncReady = 1'b1;
    step();
    iVecValid = 1'b0;
    tests++; if (oEncValid !== 1'b1) begin fails++; $display("FAIL single_evalid got=%b exp=1", oEncValid); end
    tests++; if (oEnc !== 2'd2) begin fails++; $display("FAIL single_enc got=%0d exp=2", oEnc); end
    tests++; if (oLast !== 1'b1) begin fails++; $display("FAIL single_last got=%b exp=1", oLast); end
    tests++; if (oZero !== 1'b0) begin fails++; $display("FAIL single_zero got=%b exp=0", oZero); end
    tests++; if (oVecReady !== 1'b0) begin fails++; $display("FAIL single_vready_busy got=%b exp=0", oVecReady); end
    step();
    tests++; if (oVecReady !== 1'b1) begin fails++; $display("FAIL single_vready_after got=%b exp=1", oVecReady); end
    tests++; if (oEncValid !== 1'b0) begin fails++; $display("FAIL single_evalid_after got=%b exp=0", oEncValid); end
  endtask

  task automatic test_all_ones();
    logic [1:0] exp_idx;
    iVec = 4'b1111; iVecValid = 1'b1; iEncReady = 1'b1;
    step();
    iVecValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_idx = 2'(i);
      tests++; if (oEncValid !== 1'b1) begin fails++; $display("FAIL ones_evalid beat=%0d got=%b exp=1", i, oEncValid); end
      tests++; if (oEnc !== exp_idx) begin fails++; $display("FAIL ones_enc beat=%0d got=%0d exp=%0d", i, oEnc, exp_idx); end
      tests++; if (oLast !== (i == 3)) begin fails++; $display("FAIL ones_last beat=%0d got=%b exp=%b", i, oLast, (i == 3)); end
      tests++; if (oVecReady !== 1'b0) begin fails++; $display("FAIL ones_vready beat=%0d got=%b exp=0", i, oVecReady); end
      step();
    end
    tests++; if (oVecReady !== 1'b1) begin fails++; $display("FAIL ones_vready_after got=%b exp=1", oVecReady); end
    tests++; if (oEncValid !== 1'b0) begin fails++; $display("FAIL ones_evalid_after got=%b exp=0", oEncValid); end
  endtask

  task automatic test_stall();
    iVec = 4'b1010; iVecValid = 1'b1; iEncReady = 1'b1;
    step();
    iVecValid = 1'b0; iEncReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (oEncValid !== 1'b1) begin fails++; $display("FAIL stall_evalid cyc=%0d got=%b exp=1", i, oEncValid); end
      tests++; if (oEnc !== 2'd1) begin fails++; $display("FAIL stall_enc cyc=%0d got=%0d exp=1", i, oEnc); end
      tests++; if (oLast !== 1'b0) begin fails++; $display("FAIL stall_last cyc=%0d got=%b exp=0", i, oLast); end
      if (i == 3) iEncReady = 1'b1;
      step();
    end
    tests++; if (oEnc !== 2'd3) begin fails++; $display("FAIL stall_enc2 got=%0d exp=3", oEnc); end
    tests++; if (oLast !== 1'b1) begin fails++; $display("FAIL stall_last2 got=%b exp=1", oLast); end
    tests++; if (oEncValid !== 1'b1) begin fails++; $display("FAIL stall_evalid2 got=%b exp=1", oEncValid); end
    step();
    tests++; if (oVecReady !== 1'b1) begin fails++; $display("FAIL stall_vready_after got=%b exp=1", oVecReady); end
  endtask

  task automatic test_zero();
    iVec = 4'b0000; iVecValid = 1'b1; iEncReady = 1'b1;
    step();
    iVecValid = 1'b0;
    tests++; if (oEncValid !== 1'b1) begin fails++; $display("FAIL zero_evalid got=%b exp=1", oEncValid); end
    tests++; if (oEnc !== 2'd0) begin fails++; $display("FAIL zero_enc got=%0d exp=0", oEnc); end
    tests++; if (oZero !== 1'b1) begin fails++; $display("FAIL zero_zero got=%b exp=1", oZero); end
    tests++; if (oLast !== 1'b1) begin fails++; $display("FAIL zero_last got=%b exp=1", oLast); end
    step();
    tests++; if (oEncValid !== 1'b0) begin fails++; $display("FAIL zero_evalid_after got=%b exp=0", oEncValid); end
    tests++; if (oZero !== 1'b0) begin fails++; $display("FAIL zero_zero_after got=%b exp=0", oZero); end
    tests++; if (oVecReady !== 1'b1) begin fails++; $display("FAIL zero_vready_after got=%b exp=1", oVecReady); end
  endtask

  task automatic test_reset_mid();
    iVec = 4'b1101; iVecValid = 1'b1; iEncReady = 1'b1;
    step();
    iVecValid = 1'b0;
    tests++; if (oEnc !== 2'd0) begin fails++; $display("FAIL rmid_enc0 got=%0d exp=0", oEnc); end
    step();
    tests++; if (oEnc !== 2'd2) begin fails++; $display("FAIL rmid_enc1 got=%0d exp=2", oEnc); end
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    tests++; if (oEncValid !== 1'b0) begin fails++; $display("FAIL rmid_evalid got=%b exp=0", oEncValid); end
    tests++; if (oVecReady !== 1'b1) begin fails++; $display("FAIL rmid_vready got=%b exp=1", oVecReady); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (oEncValid !== 1'b0) begin fails++; $display("FAIL rmid_no_beat cyc=%0d got=%b exp=0", i, oEncValid); end
    end
  endtask

  task automatic test_ignore_busy();
    iVec = 4'b0110; iVecValid = 1'b1; iEncReady = 1'b1;
    step();
    iVec = 4'b0001;
    tests++; if (oEnc !== 2'd1) begin fails++; $display("FAIL ign_enc0 got=%0d exp=1", oEnc); end
    tests++; if (oLast !== 1'b0) begin fails++; $display("FAIL ign_last0 got=%b exp=0", oLast); end
    step();
    tests++; if (oEnc !== 2'd2) begin fails++; $display("FAIL ign_enc1 got=%0d exp=2", oEnc); end
    tests++; if (oLast !== 1'b1) begin fails++; $display("FAIL ign_last1 got=%b exp=1", oLast); end
    step();
    iVecValid = 1'b0;
    tests++; if (oEncValid !== 1'b0) begin fails++; $display("FAIL ign_evalid_after got=%b exp=0", oEncValid); end
    tests++; if (oVecReady !== 1'b1) begin fails++; $display("FAIL ign_vready_after got=%b exp=1", oVecReady); end
    step();
    tests++; if (oEncValid !== 1'b0) begin fails++; $display("FAIL ign_no_extra got=%b exp=0", oEncValid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    iRst = 1'b1; iVec = 4'b0000; iVecValid = 1'b0; iEncReady = 1'b0;
    test_reset();
    test_single();
    test_all_ones();
    test_stall();
    test_zero();
    test_reset_mid();
    test_ignore_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/penc_stream.md
# penc_stream

Sequential priority encoder that turns a multi-hot request word into a stream of binary indices, one per set bit, lowest index first. It is the encoding-side counterpart of the 2-to-4 decoder. A decoded one-hot or multi-hot word enters on a valid/ready port. Each set bit leaves as a `W`-bit index on a second valid/ready port. Default configuration is 4-to-2.

## Interface
- `N`, default 4: width of the input request word; must be a power of two, N ≥ 2.
- `W`, default `$clog2(N)` (2): width of the encoded index.

- `iClk`  in  1: single clock; all state changes on its rising edge.
- `iRst`  in  1: synchronous reset, active-high.
- `iVec`  in  N: request word; bit `k` set means index `k` must be emitted.
- `iVecValid`  in  1: `iVec` is valid.
- `oVecReady`  out  1: block can accept a new word.
- `oEnc`  out  W: current encoded index.
- `oEncValid`  out  1: `oEnc` is valid.
- `iEncReady`  in  1: downstream consumes `oEnc` this cycle.
- `oLast`  out  1: current beat is the final beat of this word.
- `oZero`  out  1: current beat stands for an all-zero word, not a real index.

## Operation
- Registers:
  - state ∈ {IDLE, BUSY}.
  - `pend[N-1:0]`: bits not yet emitted.
  - `zflag`: set when the accepted word was all-zero.
- IDLE:
  - `oVecReady` = 1 and `oEncValid` = 0.
  - On `iVecValid` at a rising edge: `pend` ← `iVec`, `zflag` ← (`iVec` == 0), state ← BUSY.
- BUSY:
  - `oVecReady` = 0 and `oEncValid` = 1.
  - `oEnc` = index of the lowest set bit of `pend`; 0 when `zflag` = 1.
  - `oLast` = 1 when `pend` has exactly one bit set, or when `zflag` = 1.
  - `oZero` = `zflag`.
- Transfer occurs on a rising edge with `oEncValid` && `iEncReady`:
  - The bit at index `oEnc` is cleared in `pend`.
  - If `oLast` = 1: state ← IDLE and `zflag` ← 0.
- `iEncReady` = 0 in BUSY holds every output stable; `oEnc`, `oLast` and `oZero` must not change while stalled.
- All outputs are functions of registers only. There is no combinational path from any input to any output.
- An all-zero word produces exactly one beat: `oEnc` = 0, `oZero` = 1, `oLast` = 1.
- A word with all N bits set produces N beats, indices 0 to N-1 in order, with `oLast` only on index N-1.

## Timing
- Reset values, in effect on the first edge with `iRst` = 1:
  - state = IDLE, `pend` = 0, `zflag` = 0.
  - `oVecReady` = 1; `oEncValid` = `oLast` = `oZero` = 0; `oEnc` = 0.
- `iRst` has priority over every handshake.
- Reset mid-word discards the remaining `pend` bits. No further beats are emitted for that word.
- Latency: word accepted at edge t gives its first beat (`oEncValid` = 1) in the cycle after t.
- Throughput: a word with P set bits (P ≥ 1) takes P beats plus 1 IDLE cycle before the next word can be accepted. An all-zero word takes 1 beat plus 1 IDLE cycle.
- `iVec` and `iVecValid` are ignored in BUSY. Upstream must hold the word until `oVecReady` = 1.
- Handshake rules:
  - Once `oEncValid` rises it stays high until a transfer with `oLast` = 1 occurs, or until reset.
  - Downstream may assert `iEncReady` before `oEncValid` rises.

## Structure
- Shared package `enc_pkg` holds:
  - the state encoding: IDLE = 1'b0, BUSY = 1'b1;
  - a `clog2` constant function used to derive `W`.
- Sub-module `penc_lsb` (combinational, parameter `N`):
  - input `iVec`;
  - outputs `oIdx` (index of the lowest set bit), `oAny` (any bit set) and `oOne` (exactly one bit set).
  - `penc_stream` instantiates it once on `pend`.
- The top level contains only the state register, `pend`/`zflag` update logic and output assignments.

## Test plan
- Reset, then `iVec` = 4'b0100 with `iVecValid` = 1 and `iEncReady` = 1 → one beat: `oEnc` = 2, `oLast` = 1, `oZero` = 0; `oVecReady` high again on the next cycle.
- `iVec` = 4'b1111 with `iEncReady` = 1 → beats `oEnc` = 0, 1, 2, 3 on consecutive cycles; `oLast` only with 3; 5 cycles from accept to the next `oVecReady`.
- `iVec` = 4'b1010 with `iEncReady` low for 3 cycles after the first beat → `oEnc` = 1 held stable for 4 cycles, then `oEnc` = 3 with `oLast` = 1.
- `iVec` = 4'b0000 → exactly one beat: `oEnc` = 0, `oZero` = 1, `oLast` = 1.
- `iVec` = 4'b1101 accepted; assert `iRst` after the first beat transfers → next cycle `oEncValid` = 0 and `oVecReady` = 1; no further beats for this word.
- Attempt a new `iVec` = 4'b0001 while BUSY on 4'b0110 → the new word is ignored; only indices 1 and 2 are emitted.
